// File: rtl/cprv_ram_2p_arb_if.sv
// Requester-side bus of the dual-port RAM arbiter.
// Master = requesters, slave = arbiter.
interface cprv_ram_2p_arb_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 64
);
    logic [NUM_REQ-1:0]            req_i;
    logic [NUM_REQ-1:0]            we_i;
    logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i;
    logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i;
    logic [NUM_REQ-1:0]            gnt_o;
    logic [NUM_REQ-1:0]            rvalid_o;
    logic [NUM_REQ*DATA_WIDTH-1:0] rdata_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o
    );
endinterface

// File: rtl/cprv_ram_2p_arb.sv
// Round-robin arbiter sharing the two cprv_ram_2p ports among NUM_REQ clients.
// Optional macro CPRV_RAM_ARB_HAZARD_EN defers port 2 on same-address write hazards.
module cprv_ram_2p_arb #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    cprv_ram_2p_arb_if.slave      bus,
    output logic                  ram_w_en1,
    output logic                  ram_w_en2,
    output logic [ADDR_WIDTH-1:0] ram_addr1,
    output logic [ADDR_WIDTH-1:0] ram_addr2,
    output logic [DATA_WIDTH-1:0] ram_wdata1,
    output logic [DATA_WIDTH-1:0] ram_wdata2,
    input  logic [DATA_WIDTH-1:0] ram_rdata1,
    input  logic [DATA_WIDTH-1:0] ram_rdata2
);
    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] a_idx, b_idx;
    logic          a_vld, b_vld;
    logic          a_gnt, b_gnt;
    logic          b_haz;
    logic          rsp_vld1, rsp_vld2;
    logic [PW-1:0] rsp_id1, rsp_id2;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] x);
        return PW'((int'(x) + 1) % NUM_REQ);
    endfunction

    // Port 1 picks the first requester at or after rr_ptr
    always_comb begin
        a_vld = 1'b0;
        a_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!a_vld && bus.req_i[(int'(rr_ptr) + k) % NUM_REQ]) begin
                a_vld = 1'b1;
                a_idx = PW'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    // Port 2 picks the next requester after port 1's winner
    always_comb begin
        b_vld = 1'b0;
        b_idx = '0;
        for (int k = 1; k < NUM_REQ; k++) begin
            if (a_vld && !b_vld && bus.req_i[(int'(a_idx) + k) % NUM_REQ]) begin
                b_vld = 1'b1;
                b_idx = PW'((int'(a_idx) + k) % NUM_REQ);
            end
        end
    end

    // Same-address hazard check between the two candidates
    always_comb begin
        b_haz = 1'b0;
`ifdef CPRV_RAM_ARB_HAZARD_EN
        b_haz = b_vld
             && (bus.addr_i[int'(a_idx)*ADDR_WIDTH +: ADDR_WIDTH]
              == bus.addr_i[int'(b_idx)*ADDR_WIDTH +: ADDR_WIDTH])
             && (bus.we_i[a_idx] || bus.we_i[b_idx]);
`endif
    end

    // Final grants, blocked while reset is high
    always_comb begin
        a_gnt = a_vld && !rst;
        b_gnt = b_vld && !b_haz && !rst;
        bus.gnt_o = '0;
        if (a_gnt) bus.gnt_o[a_idx] = 1'b1;
        if (b_gnt) bus.gnt_o[b_idx] = 1'b1;
    end

    // Drive RAM ports from the winners; idle ports read address 0
    always_comb begin
        ram_w_en1  = 1'b0;
        ram_addr1  = '0;
        ram_wdata1 = '0;
        ram_w_en2  = 1'b0;
        ram_addr2  = '0;
        ram_wdata2 = '0;
        if (a_gnt) begin
            ram_w_en1  = bus.we_i[a_idx];
            ram_addr1  = bus.addr_i[int'(a_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            ram_wdata1 = bus.wdata_i[int'(a_idx)*DATA_WIDTH +: DATA_WIDTH];
        end
        if (b_gnt) begin
            ram_w_en2  = bus.we_i[b_idx];
            ram_addr2  = bus.addr_i[int'(b_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            ram_wdata2 = bus.wdata_i[int'(b_idx)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Round-robin pointer moves past the last granted requester
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (a_gnt) begin
            rr_ptr <= b_gnt ? inc(b_idx) : inc(a_idx);
        end
    end

    // Remember which requester each port's read belongs to
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_vld1 <= 1'b0;
            rsp_vld2 <= 1'b0;
            rsp_id1  <= '0;
            rsp_id2  <= '0;
        end else begin
            rsp_vld1 <= a_gnt && !bus.we_i[a_idx];
            rsp_vld2 <= b_gnt && !bus.we_i[b_idx];
            rsp_id1  <= a_idx;
            rsp_id2  <= b_idx;
        end
    end

    // Route registered RAM read data back to its requester
    always_comb begin
        bus.rvalid_o = '0;
        bus.rdata_o  = '0;
        if (rsp_vld1) begin
            bus.rvalid_o[rsp_id1] = 1'b1;
            bus.rdata_o[int'(rsp_id1)*DATA_WIDTH +: DATA_WIDTH] = ram_rdata1;
        end
        if (rsp_vld2) begin
            bus.rvalid_o[rsp_id2] = 1'b1;
            bus.rdata_o[int'(rsp_id2)*DATA_WIDTH +: DATA_WIDTH] = ram_rdata2;
        end
    end
endmodule

// File: tb/tb_cprv_ram_2p_arb.sv
// Directed bench for cprv_ram_2p_arb with a behavioural dual-port RAM.
// Unwritten RAM words read as 0x1000 + address.
module tb_cprv_ram_2p_arb;
    logic        clk = 1'b0;
    logic        rst;
    logic        ram_w_en1, ram_w_en2;
    logic [6:0]  ram_addr1, ram_addr2;
    logic [63:0] ram_wdata1, ram_wdata2;
    logic [63:0] ram_rdata1, ram_rdata2;
    int          total = 0;
    int          bad = 0;

    logic [63:0]  mem [0:127];
    logic [127:0] wr = '0;

    cprv_ram_2p_arb_if #(.NUM_REQ(4), .ADDR_WIDTH(7), .DATA_WIDTH(64)) bus();

    cprv_ram_2p_arb dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .ram_w_en1  (ram_w_en1),
        .ram_w_en2  (ram_w_en2),
        .ram_addr1  (ram_addr1),
        .ram_addr2  (ram_addr2),
        .ram_wdata1 (ram_wdata1),
        .ram_wdata2 (ram_wdata2),
        .ram_rdata1 (ram_rdata1),
        .ram_rdata2 (ram_rdata2)
    );

    always #5 clk = ~clk;

    // Registered-output dual-port RAM model
    always @(posedge clk) begin
        ram_rdata1 <= wr[ram_addr1] ? mem[ram_addr1] : 64'h1000 + {57'd0, ram_addr1};
        ram_rdata2 <= wr[ram_addr2] ? mem[ram_addr2] : 64'h1000 + {57'd0, ram_addr2};
        if (ram_w_en1) begin
            mem[ram_addr1] <= ram_wdata1;
            wr[ram_addr1]  <= 1'b1;
        end
        if (ram_w_en2) begin
            mem[ram_addr2] <= ram_wdata2;
            wr[ram_addr2]  <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] slot(input int i, input logic [63:0] v);
        logic [255:0] r;
        r = '0;
        r[i*64 +: 64] = v;
        return r;
    endfunction

    task automatic clr();
        bus.req_i   = '0;
        bus.we_i    = '0;
        bus.addr_i  = '0;
        bus.wdata_i = '0;
    endtask

    task automatic drv(input int i, input logic w, input logic [6:0] a, input logic [63:0] d);
        bus.req_i[i]           = 1'b1;
        bus.we_i[i]            = w;
        bus.addr_i[i*7 +: 7]   = a;
        bus.wdata_i[i*64 +: 64] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        clr();
        rst = 1'b1;
        tick();
        // reset: grants and write enables held off even with requests
        for (int i = 0; i < 4; i++) drv(i, 1'b1, 7'(i), 64'h55);
        #1;
        chk("rst_gnt", 256'(bus.gnt_o), 256'h0);
        chk("rst_wen", 256'({ram_w_en1, ram_w_en2}), 256'h0);
        chk("rst_rvalid", 256'(bus.rvalid_o), 256'h0);
        chk("rst_rdata", bus.rdata_o, 256'h0);
        chk("rst_ptr", 256'(dut.rr_ptr), 256'h0);
        clr();
        rst = 1'b0;
        #1;
        chk("idle_gnt", 256'(bus.gnt_o), 256'h0);
        chk("idle_wen", 256'({ram_w_en1, ram_w_en2}), 256'h0);
        chk("idle_addr", 256'({ram_addr1, ram_addr2}), 256'h0);
        tick();

        // single read
        drv(0, 1'b0, 7'd5, 64'h0);
        #1;
        chk("t1_gnt", 256'(bus.gnt_o), 256'h1);
        chk("t1_addr1", 256'(ram_addr1), 256'd5);
        tick();
        clr();
        #1;
        chk("t1_rvalid", 256'(bus.rvalid_o), 256'h1);
        chk("t1_rdata", bus.rdata_o, slot(0, 64'h1005));
        drv(3, 1'b0, 7'd7, 64'h0);
        #1;
        chk("t1b_gnt", 256'(bus.gnt_o), 256'h8);
        tick();
        clr();
        #1;
        chk("t1b_rvalid", 256'(bus.rvalid_o), 256'h8);
        chk("t1b_rdata", bus.rdata_o, slot(3, 64'h1007));
        chk("t1b_ptr", 256'(dut.rr_ptr), 256'h0);

        // all four read
        for (int i = 0; i < 4; i++) drv(i, 1'b0, 7'(10 + i), 64'h0);
        #1;
        chk("t2_gnt0", 256'(bus.gnt_o), 256'h3);
        chk("t2_addr", 256'({ram_addr1, ram_addr2}), 256'({7'd10, 7'd11}));
        tick();
        clr();
        drv(2, 1'b0, 7'd12, 64'h0);
        drv(3, 1'b0, 7'd13, 64'h0);
        #1;
        chk("t2_gnt1", 256'(bus.gnt_o), 256'hc);
        chk("t2_rv0", 256'(bus.rvalid_o), 256'h3);
        chk("t2_rd0", bus.rdata_o, slot(0, 64'h100a) | slot(1, 64'h100b));
        chk("t2_ptr1", 256'(dut.rr_ptr), 256'h2);
        tick();
        clr();
        #1;
        chk("t2_rv1", 256'(bus.rvalid_o), 256'hc);
        chk("t2_rd1", bus.rdata_o, slot(2, 64'h100c) | slot(3, 64'h100d));
        chk("t2_ptr2", 256'(dut.rr_ptr), 256'h0);

        // write then read
        drv(0, 1'b1, 7'd9, 64'hdead_beef);
        #1;
        chk("t3_gnt_w", 256'(bus.gnt_o), 256'h1);
        chk("t3_wen1", 256'(ram_w_en1), 256'h1);
        tick();
        clr();
        drv(1, 1'b0, 7'd9, 64'h0);
        #1;
        chk("t3_gnt_r", 256'(bus.gnt_o), 256'h2);
        chk("t3_no_wrsp", 256'(bus.rvalid_o), 256'h0);
        tick();
        clr();
        #1;
        chk("t3_rvalid", 256'(bus.rvalid_o), 256'h2);
        chk("t3_rdata", bus.rdata_o, slot(1, 64'hdead_beef));

        // same-address double write
        drv(0, 1'b1, 7'd3, 64'haaaa);
        drv(1, 1'b1, 7'd3, 64'hbbbb);
        #1;
`ifdef CPRV_RAM_ARB_HAZARD_EN
        chk("t4_gnt", 256'(bus.gnt_o), 256'h1);
        tick();
        clr();
        drv(1, 1'b1, 7'd3, 64'hbbbb);
        #1;
        chk("t4_gnt2", 256'(bus.gnt_o), 256'h2);
        tick();
        clr();
`else
        chk("t4_gnt", 256'(bus.gnt_o), 256'h3);
        tick();
        clr();
`endif
        drv(2, 1'b0, 7'd3, 64'h0);
        #1;
        chk("t4_rd_gnt", 256'(bus.gnt_o), 256'h4);
        tick();
        clr();
        #1;
        chk("t4_rvalid", 256'(bus.rvalid_o), 256'h4);
`ifdef CPRV_RAM_ARB_HAZARD_EN
        chk("t4_mem3", bus.rdata_o, slot(2, 64'hbbbb));
`endif

        // req0 held, req2 raised
        drv(0, 1'b0, 7'd20, 64'h0);
        drv(2, 1'b0, 7'd21, 64'h0);
        #1;
        chk("t5_gnt0", 256'(bus.gnt_o), 256'h5);
        tick();
        clr();
        drv(0, 1'b0, 7'd22, 64'h0);
        #1;
        chk("t5_gnt1", 256'(bus.gnt_o), 256'h1);
        chk("t5_rv0", 256'(bus.rvalid_o), 256'h5);
        chk("t5_rd0", bus.rdata_o, slot(0, 64'h1014) | slot(2, 64'h1015));
        tick();
        clr();
        #1;
        chk("t5_rv1", 256'(bus.rvalid_o), 256'h1);
        chk("t5_rd1", bus.rdata_o, slot(0, 64'h1016));

        // reset during the response cycle of a read
        drv(1, 1'b0, 7'd30, 64'h0);
        #1;
        chk("t6_gnt", 256'(bus.gnt_o), 256'h2);
        tick();
        clr();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) drv(i, 1'b1, 7'(40 + i), 64'h77);
        #1;
        chk("t6_rvalid", 256'(bus.rvalid_o), 256'h0);
        chk("t6_rdata", bus.rdata_o, 256'h0);
        chk("t6_gnt_rst", 256'(bus.gnt_o), 256'h0);
        chk("t6_wen", 256'({ram_w_en1, ram_w_en2}), 256'h0);
        tick();
        rst = 1'b0;
        clr();
        #1;
        chk("t6_ptr", 256'(dut.rr_ptr), 256'h0);
        chk("t6_rv_after", 256'(bus.rvalid_o), 256'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
